// File: rtl/serial_frame_rx_pkg.sv
// Shared serial-link definitions: receiver state encoding, even-parity helper, default baud divisor.
// The default baud divisor is shared with the transmitter.
package serial_frame_rx_pkg;

  localparam int unsigned DefaultClksPerBit = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  // Even parity over the low 'width' bits of a word of up to 9 bits.
  function automatic logic even_parity(input logic [8:0] data, input int unsigned width);
    logic acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < width) acc = acc ^ data[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/serial_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; both flops reset to 1.
module serial_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling async serial frame receiver (8N1 default) with valid/ready output register.
// Optional parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_W - 1);

  logic rxs;

  serial_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              armed_q, armed_d;
  logic              stop_tick;
  logic              par_bad;
  logic              good;
  logic              load;

`ifdef SERIAL_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_tick = 1'b0;
    // A line held low after a frame must go high once before a new start is accepted.
    armed_d   = armed_q | rxs;
`ifdef SERIAL_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!rxs && armed_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          for (int i = 0; i < int'(DATA_W); i++) begin
            if (idx_q == IdxW'(i)) shift_d[i] = rxs;
          end
          if (idx_q == IdxLast) begin
            idx_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_err_d = (rxs != even_parity(9'(shift_q), DATA_W));
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          stop_tick = 1'b1;
          state_d   = StIdle;
          if (!rxs) armed_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign good = stop_tick && rxs && !par_bad;
  assign load = good && (!valid_q || rx_ready);

  always_comb begin
    data_d  = load ? shift_q : data_q;
    ferr_d  = stop_tick && (!rxs || par_bad);
    ovr_d   = good && valid_q && !rx_ready;
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      armed_q <= armed_d;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (8 data bits, 16 clocks per bit).
module tb_serial_frame_rx;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;
  int unsigned vcycles  = 0;
  int unsigned fe_cnt   = 0;
  int unsigned ov_cnt   = 0;
  logic [7:0]  last_data = '0;

  always #5 clk = ~clk;

  serial_frame_rx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      vcycles   = vcycles + 1;
      last_data = rx_data;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun)   ov_cnt = ov_cnt + 1;
  end

  task automatic clear_mon();
    vcycles   = 0;
    fe_cnt    = 0;
    ov_cnt    = 0;
    last_data = '0;
  endtask

  task automatic idle(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_good_frame();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(4);
    chk_cnt++; if (vcycles !== 1) $display("FAIL a5_valid_cycles: got %0d want 1", vcycles); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", last_data); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL a5_ferr: got %0d want 0", fe_cnt); else pass_cnt++;
    chk_cnt++; if (ov_cnt !== 0) $display("FAIL a5_ovr: got %0d want 0", ov_cnt); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL a5_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h3C, ^8'h3C, 1'b1);
    idle(4);
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_first_valid: got %b want 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h3C) $display("FAIL ovr_first_data: got %h want 3c", rx_data); else pass_cnt++;
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(4);
    chk_cnt++; if (ov_cnt !== 1) $display("FAIL ovr_pulses: got %0d want 1", ov_cnt); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h3C) $display("FAIL ovr_data_held: got %h want 3c", rx_data); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL ovr_ferr: got %0d want 0", fe_cnt); else pass_cnt++;
    rx_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_handshake_clear: got %b want 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h55, ^8'h55, 1'b0);
    idle(2 * Cpb);
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL ferr_pulses: got %0d want 1", fe_cnt); else pass_cnt++;
    chk_cnt++; if (vcycles !== 0) $display("FAIL ferr_valid: got %0d want 0", vcycles); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL ferr_busy: got %b want 0", busy); else pass_cnt++;
    clear_mon();
    send_frame(8'h12, ^8'h12, 1'b1);
    idle(4);
    chk_cnt++; if (vcycles !== 1) $display("FAIL ferr_next_valid: got %0d want 1", vcycles); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'h12) $display("FAIL ferr_next_data: got %h want 12", last_data); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL ferr_next_ferr: got %0d want 0", fe_cnt); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic        seen;
    logic        ok;
    int unsigned fall;
    clear_mon();
    seen = 1'b0;
    fall = 0;
    rxd  = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) rxd = 1'b1;
      if (busy) seen = 1'b1;
      else if (seen && fall == 0) fall = i;
    end
    ok = (fall != 0) && (fall <= Cpb / 2 + 3);
    chk_cnt++; if (seen !== 1'b1) $display("FAIL glitch_busy_seen: got %b want 1", seen); else pass_cnt++;
    chk_cnt++; if (ok !== 1'b1) $display("FAIL glitch_busy_fall: got cycle %0d want 1..%0d", fall, Cpb / 2 + 3); else pass_cnt++;
    chk_cnt++; if (vcycles !== 0) $display("FAIL glitch_valid: got %0d want 0", vcycles); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL glitch_ferr: got %0d want 0", fe_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (Cpb / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", rx_valid); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * Cpb);
    send_frame(8'h0F, ^8'h0F, 1'b1);
    idle(4);
    chk_cnt++; if (vcycles !== 1) $display("FAIL rstmid_valid_cycles: got %0d want 1", vcycles); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'h0F) $display("FAIL rstmid_data: got %h want 0f", last_data); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL rstmid_ferr: got %0d want 0", fe_cnt); else pass_cnt++;
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL par_bad_ferr: got %0d want 1", fe_cnt); else pass_cnt++;
    chk_cnt++; if (vcycles !== 0) $display("FAIL par_bad_valid: got %0d want 0", vcycles); else pass_cnt++;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    chk_cnt++; if (last_data !== 8'h07) $display("FAIL par_good_data: got %h want 07", last_data); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL par_good_ferr: got %0d want 0", fe_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    idle(5);
    test_good_frame();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
